// File: rtl/parking_gate_ctrl.sv
// Single-barrier parking gate controller: occupancy tracking, entry/exit arbitration
// with one buffered request per direction, and a fixed gate hold time.
module parking_gate_ctrl #(
    parameter int CLK_FREQUENCY = 40_000_000,
    parameter int GATE_HOLD_SEC = 3,
    parameter int CAPACITY      = 8,
    localparam int OCC_W        = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic             gate_open,
    output logic             gate_dir,
    output logic [OCC_W-1:0] occupancy,
    output logic [OCC_W-1:0] free_spaces,
    output logic             full,
    output logic             empty,
    output logic             reject
);
    localparam int HOLD_CYCLES = CLK_FREQUENCY * GATE_HOLD_SEC;
    localparam int TMR_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [OCC_W-1:0] CAP_V     = OCC_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT} state_t;

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             pend_entry_q, pend_exit_q;
    logic [OCC_W-1:0] occ_q, free_q;
    logic             full_q, empty_q, reject_q, gate_open_q, gate_dir_q;

    logic             eff_entry, eff_exit;
    logic [OCC_W-1:0] occ_d;

    // Next occupancy is shared by the FSM and the status flags so they never lag.
    always_comb begin
        eff_exit  = exit_req | pend_exit_q;
        eff_entry = entry_req | pend_entry_q;
        occ_d     = occ_q;
        if (state_q == IDLE) begin
            if (eff_exit) begin
                if (occ_q != '0) occ_d = occ_q - 1'b1;
            end else if (eff_entry) begin
                if (occ_q != CAP_V) occ_d = occ_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            pend_entry_q <= 1'b0;
            pend_exit_q  <= 1'b0;
            occ_q        <= '0;
            free_q       <= CAP_V;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            reject_q     <= 1'b0;
            gate_open_q  <= 1'b0;
            gate_dir_q   <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            occ_q    <= occ_d;
            free_q   <= CAP_V - occ_d;
            full_q   <= (occ_d == CAP_V);
            empty_q  <= (occ_d == '0);
            case (state_q)
                IDLE: begin
                    if (eff_exit) begin
                        pend_exit_q  <= 1'b0;
                        pend_entry_q <= eff_entry;
                        if (occ_q != '0) begin
                            state_q     <= OPEN_OUT;
                            gate_open_q <= 1'b1;
                            gate_dir_q  <= 1'b1;
                            timer_q     <= '0;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end else if (eff_entry) begin
                        pend_entry_q <= 1'b0;
                        if (occ_q != CAP_V) begin
                            state_q     <= OPEN_IN;
                            gate_open_q <= 1'b1;
                            gate_dir_q  <= 1'b0;
                            timer_q     <= '0;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    timer_q <= timer_q + 1'b1;
                    if (entry_req) pend_entry_q <= 1'b1;
                    if (exit_req)  pend_exit_q  <= 1'b1;
                    if (timer_q == TMR_LAST) begin
                        state_q     <= IDLE;
                        gate_open_q <= 1'b0;
                        timer_q     <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gate_open   = gate_open_q;
    assign gate_dir    = gate_dir_q;
    assign occupancy   = occ_q;
    assign free_spaces = free_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign reject      = reject_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with a 10-cycle hold and two spaces.
module tb_parking_gate_ctrl;
    localparam int OCC_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             entry_req = 1'b0;
    logic             exit_req = 1'b0;
    logic             gate_open, gate_dir, full, empty, reject;
    logic [OCC_W-1:0] occupancy, free_spaces;

    int errors = 0;
    int checks = 0;

    parking_gate_ctrl #(.CLK_FREQUENCY(10), .GATE_HOLD_SEC(1), .CAPACITY(2)) dut (
        .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
        .gate_open(gate_open), .gate_dir(gate_dir), .occupancy(occupancy),
        .free_spaces(free_spaces), .full(full), .empty(empty), .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles the gate stays high, starting from the current (open) cycle.
    task automatic wait_close(output int n);
        n = 0;
        while (gate_open === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    int n;
    bit opened;

    initial begin
        // 1: reset and idle
        tick();
        chk("rst_async_gate", {31'd0, gate_open}, 32'd0);
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rst_occ",   {30'd0, occupancy}, 32'd0);
        chk("rst_free",  {30'd0, free_spaces}, 32'd2);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full}, 32'd0);
        chk("rst_gate",  {31'd0, gate_open}, 32'd0);
        chk("rst_rej",   {31'd0, reject}, 32'd0);
        chk("rst_dir",   {31'd0, gate_dir}, 32'd0);

        // 2: first entry
        entry_req = 1'b1; tick(); entry_req = 1'b0;
        chk("e1_gate",  {31'd0, gate_open}, 32'd1);
        chk("e1_dir",   {31'd0, gate_dir}, 32'd0);
        chk("e1_occ",   {30'd0, occupancy}, 32'd1);
        chk("e1_empty", {31'd0, empty}, 32'd0);
        chk("e1_free",  {30'd0, free_spaces}, 32'd1);
        wait_close(n);
        chk("e1_hold", n, 32'd10);
        chk("e1_closed", {31'd0, gate_open}, 32'd0);

        // 3: fill the lot, then a refused entry
        entry_req = 1'b1; tick(); entry_req = 1'b0;
        chk("e2_occ",  {30'd0, occupancy}, 32'd2);
        chk("e2_full", {31'd0, full}, 32'd1);
        chk("e2_free", {30'd0, free_spaces}, 32'd0);
        wait_close(n);
        chk("e2_hold", n, 32'd10);
        entry_req = 1'b1; tick(); entry_req = 1'b0;
        chk("e3_rej",  {31'd0, reject}, 32'd1);
        chk("e3_gate", {31'd0, gate_open}, 32'd0);
        chk("e3_occ",  {30'd0, occupancy}, 32'd2);
        tick();
        chk("e3_rej_pulse", {31'd0, reject}, 32'd0);
        chk("e3_gate2", {31'd0, gate_open}, 32'd0);

        // 4: drop to 1, then simultaneous entry+exit
        exit_req = 1'b1; tick(); exit_req = 1'b0;
        chk("x1_dir", {31'd0, gate_dir}, 32'd1);
        chk("x1_occ", {30'd0, occupancy}, 32'd1);
        wait_close(n);
        entry_req = 1'b1; exit_req = 1'b1; tick(); entry_req = 1'b0; exit_req = 1'b0;
        chk("sim_gate", {31'd0, gate_open}, 32'd1);
        chk("sim_dir",  {31'd0, gate_dir}, 32'd1);
        chk("sim_occ",  {30'd0, occupancy}, 32'd0);
        chk("sim_empty", {31'd0, empty}, 32'd1);
        wait_close(n);
        chk("sim_hold", n, 32'd10);
        chk("sim_gap_gate", {31'd0, gate_open}, 32'd0);
        tick();
        chk("sim_pend_gate", {31'd0, gate_open}, 32'd1);
        chk("sim_pend_dir",  {31'd0, gate_dir}, 32'd0);
        chk("sim_pend_occ",  {30'd0, occupancy}, 32'd1);
        wait_close(n);

        // 5: empty the lot, refused exit, pending entry during an opening
        exit_req = 1'b1; tick(); exit_req = 1'b0;
        chk("x2_occ", {30'd0, occupancy}, 32'd0);
        wait_close(n);
        exit_req = 1'b1; tick(); exit_req = 1'b0;
        chk("x3_rej",  {31'd0, reject}, 32'd1);
        chk("x3_gate", {31'd0, gate_open}, 32'd0);
        chk("x3_occ",  {30'd0, occupancy}, 32'd0);
        tick();
        chk("x3_rej_pulse", {31'd0, reject}, 32'd0);
        entry_req = 1'b1; tick(); entry_req = 1'b0;
        chk("e4_gate", {31'd0, gate_open}, 32'd1);
        entry_req = 1'b1; tick(); entry_req = 1'b0;
        wait_close(n);
        chk("e4_hold_rest", n, 32'd9);
        chk("e4_gap", {31'd0, gate_open}, 32'd0);
        tick();
        chk("e5_gate", {31'd0, gate_open}, 32'd1);
        chk("e5_occ",  {30'd0, occupancy}, 32'd2);
        chk("e5_rej",  {31'd0, reject}, 32'd0);
        wait_close(n);

        // 6: reset during the 4th open cycle with an entry pending
        exit_req = 1'b1; tick(); exit_req = 1'b0;
        chk("x4_occ", {30'd0, occupancy}, 32'd1);
        entry_req = 1'b1; tick(); entry_req = 1'b0;
        tick();
        tick();
        chk("x4_open4", {31'd0, gate_open}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_gate",  {31'd0, gate_open}, 32'd0);
        chk("ar_occ",   {30'd0, occupancy}, 32'd0);
        chk("ar_free",  {30'd0, free_spaces}, 32'd2);
        chk("ar_empty", {31'd0, empty}, 32'd1);
        tick();
        reset_n = 1'b1;
        opened = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (gate_open !== 1'b0) opened = 1'b1;
        end
        chk("ar_no_open", {31'd0, opened}, 32'd0);
        chk("ar_occ_after", {30'd0, occupancy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
